// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and counter widths for the unified memory port arbiter
package mem_arb_pkg;
  localparam int LAT_W = 3;
  localparam int STARVE_W = 4;
  typedef enum logic {ARB_IDLE, ARB_RD_WAIT} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-priority winner select with a starvation counter that forces fetch progress
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic issue_allowed,
  output logic grant_i,
  output logic grant_d
);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                starved;
  always_comb begin
    starved = starve_cnt_q == LIMIT;
    grant_i = issue_allowed && i_req && (!d_req || starved);
    grant_d = issue_allowed && d_req && !grant_i;
    starve_cnt_d = (!i_req || grant_i) ? '0 :
                   grant_d ? (starved ? LIMIT : starve_cnt_q + 1'b1) : starve_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else starve_cnt_q <= starve_cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory between fetch (I) and load/store (D) with one read in flight
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);
  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0]       i_rdata_q, d_rdata_q;
  logic              resp, issue_allowed, grant_i, grant_d, rd_issue;
  // Reset gates the response and issue paths so an in-flight read never surfaces.
  assign resp = !rst && state_q == ARB_RD_WAIT && lat_cnt_q == '0;
  assign issue_allowed = !rst && (state_q == ARB_IDLE || resp);
  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .d_req        (d_req),
    .issue_allowed(issue_allowed),
    .grant_i      (grant_i),
    .grant_d      (grant_d)
  );
  always_comb begin
    i_gnt     = grant_i;
    d_gnt     = grant_d;
    i_rvalid  = resp && owner_q == OWN_I;
    d_rvalid  = resp && owner_q == OWN_D;
    i_rdata   = i_rvalid ? mem_rdata : i_rdata_q;
    d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
    mem_en    = grant_i || grant_d;
    mem_we    = grant_d && d_we;
    mem_addr  = grant_d ? d_addr : grant_i ? i_addr : 32'h0;
    mem_wdata = grant_d ? d_wdata : 32'h0;
    mem_be    = grant_d ? d_be : grant_i ? 4'hF : 4'h0;
    rd_issue  = grant_i || (grant_d && !d_we);
    state_d   = (rd_issue || (state_q == ARB_RD_WAIT && !resp)) ? ARB_RD_WAIT : ARB_IDLE;
    lat_cnt_d = rd_issue ? LAT_W'(MEM_LATENCY - 1) : (lat_cnt_q != '0) ? lat_cnt_q - 1'b1 : '0;
    owner_d   = rd_issue ? (grant_i ? OWN_I : OWN_D) : owner_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_I;
      lat_cnt_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation and reset for two latency configs
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        i3_req, d3_req, d3_we;
  logic [31:0] i3_addr, d3_addr;
  logic        i3_gnt, i3_rvalid, d3_gnt, d3_rvalid, m3_en, m3_we;
  logic [31:0] i3_rdata, d3_rdata, m3_addr, m3_wdata, m3_rdata;
  logic [3:0]  m3_be;
  logic [31:0] mem [0:255];
  logic [31:0] p0, p1, p2;
  int          total = 0, passed = 0, fails = 0;
  logic        exp_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i3_req), .i_addr(i3_addr), .i_gnt(i3_gnt), .i_rvalid(i3_rvalid), .i_rdata(i3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(32'h0), .d_be(4'h0),
    .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_be(m3_be), .mem_rdata(m3_rdata)
  );

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  always @(posedge clk) begin
    p0 <= (m3_en && !m3_we) ? ~m3_addr : 32'h0;
    p1 <= p0;
    p2 <= p1;
  end
  assign m3_rdata = p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;
    mem[0] = 32'h0050_0093;
    mem_rdata = 32'h0;
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    i3_req = 1'b0; i3_addr = 32'h0; d3_req = 1'b0; d3_we = 1'b0; d3_addr = 32'h0;
    step(); step();
    #1;
    chk("reset i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("reset i_rdata", i_rdata, 32'h0);
    chk("reset d_rdata", d_rdata, 32'h0);
    chk("reset mem_en", {31'b0, mem_en}, 32'h0);

    rst = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    #1;
    chk("midrd i_gnt", {31'b0, i_gnt}, 32'h1);
    chk("midrd mem_addr", mem_addr, 32'h10);
    step();
    i_req = 1'b0; rst = 1'b1;
    #1;
    chk("midrd rst i_rvalid", {31'b0, i_rvalid}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    chk("midrd after i_rvalid", {31'b0, i_rvalid}, 32'h0);
    chk("midrd after i_rdata", i_rdata, 32'h0);
    chk("midrd after mem_en", {31'b0, mem_en}, 32'h0);
    chk("midrd after gnt", {30'b0, i_gnt, d_gnt}, 32'h0);
    step();
    #1;
    chk("midrd later i_rvalid", {31'b0, i_rvalid}, 32'h0);

    step();
    i_req = 1'b1; i_addr = 32'h0;
    #1;
    chk("fetch i_gnt", {31'b0, i_gnt}, 32'h1);
    chk("fetch d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("fetch mem_en", {31'b0, mem_en}, 32'h1);
    chk("fetch mem_addr", mem_addr, 32'h0);
    chk("fetch mem_we", {31'b0, mem_we}, 32'h0);
    chk("fetch mem_be", {28'b0, mem_be}, 32'hF);
    step();
    i_req = 1'b0;
    #1;
    chk("fetch i_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("fetch i_rdata", i_rdata, 32'h0050_0093);
    chk("fetch d_rvalid", {31'b0, d_rvalid}, 32'h0);
    step();
    #1;
    chk("fetch pulse end", {31'b0, i_rvalid}, 32'h0);
    chk("fetch rdata hold", i_rdata, 32'h0050_0093);

    step();
    i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    #1;
    chk("both d_gnt", {31'b0, d_gnt}, 32'h1);
    chk("both i_gnt c0", {31'b0, i_gnt}, 32'h0);
    chk("both mem_addr c0", mem_addr, 32'h100);
    step();
    d_req = 1'b0;
    #1;
    chk("both d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("both d_rdata", d_rdata, 32'h1000_0040);
    chk("both i_gnt c1", {31'b0, i_gnt}, 32'h1);
    chk("both mem_addr c1", mem_addr, 32'h4);
    chk("both i_rvalid c1", {31'b0, i_rvalid}, 32'h0);
    step();
    i_req = 1'b0;
    #1;
    chk("both i_rvalid c2", {31'b0, i_rvalid}, 32'h1);
    chk("both i_rdata", i_rdata, 32'h1000_0001);
    chk("both d_rvalid c2", {31'b0, d_rvalid}, 32'h0);
    chk("both d_rdata hold", d_rdata, 32'h1000_0040);

    for (int k = 0; k < 3; k++) begin
      step();
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
      d_addr = 32'h200 + 32'(4 * k); d_wdata = 32'hAABB_1111 + 32'(k);
      #1;
      chk("store d_gnt", {31'b0, d_gnt}, 32'h1);
      chk("store mem_we", {31'b0, mem_we}, 32'h1);
      chk("store mem_be", {28'b0, mem_be}, 32'h3);
      chk("store mem_addr", mem_addr, 32'h200 + 32'(4 * k));
      chk("store mem_wdata", mem_wdata, 32'hAABB_1111 + 32'(k));
      chk("store d_rvalid", {31'b0, d_rvalid}, 32'h0);
    end
    step();
    d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("store idle d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("store idle mem_en", {31'b0, mem_en}, 32'h0);
    step();
    d_req = 1'b1; d_addr = 32'h200;
    #1;
    chk("ld d_gnt", {31'b0, d_gnt}, 32'h1);
    step();
    d_req = 1'b0;
    #1;
    chk("ld d_rvalid", {31'b0, d_rvalid}, 32'h1);
    chk("ld merged data", d_rdata, 32'h1000_1111);

    step();
    i_req = 1'b1; i_addr = 32'hFFFF_FFFC;
    #1;
    chk("top addr i_gnt", {31'b0, i_gnt}, 32'h1);
    chk("top addr mem_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    i_req = 1'b0;
    #1;
    chk("top addr i_rvalid", {31'b0, i_rvalid}, 32'h1);
    chk("top addr i_rdata", i_rdata, 32'h1000_00FF);

    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) begin
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h300; d_wdata = 32'h0;
      end
      #1;
      exp_i = (c == 4) || (c == 9);
      chk("starve i_gnt", {31'b0, i_gnt}, {31'b0, exp_i});
      chk("starve d_gnt", {31'b0, d_gnt}, {31'b0, !exp_i});
      if (c == 5) chk("starve i_rdata", i_rdata, 32'h1000_0002);
    end
    step();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("starve final i_rvalid", {31'b0, i_rvalid}, 32'h1);

    step();
    d3_req = 1'b1; d3_we = 1'b0; d3_addr = 32'h40; i3_req = 1'b1; i3_addr = 32'h80;
    #1;
    chk("lat3 d_gnt c0", {31'b0, d3_gnt}, 32'h1);
    chk("lat3 i_gnt c0", {31'b0, i3_gnt}, 32'h0);
    step();
    d3_req = 1'b0;
    #1;
    chk("lat3 i_gnt c1", {31'b0, i3_gnt}, 32'h0);
    chk("lat3 d_rvalid c1", {31'b0, d3_rvalid}, 32'h0);
    step();
    #1;
    chk("lat3 i_gnt c2", {31'b0, i3_gnt}, 32'h0);
    chk("lat3 mem_en c2", {31'b0, m3_en}, 32'h0);
    step();
    #1;
    chk("lat3 d_rvalid c3", {31'b0, d3_rvalid}, 32'h1);
    chk("lat3 d_rdata c3", d3_rdata, 32'hFFFF_FFBF);
    chk("lat3 i_gnt c3", {31'b0, i3_gnt}, 32'h1);
    step();
    i3_req = 1'b0;
    #1;
    chk("lat3 i_rvalid c4", {31'b0, i3_rvalid}, 32'h0);
    step();
    #1;
    chk("lat3 i_rvalid c5", {31'b0, i3_rvalid}, 32'h0);
    step();
    #1;
    chk("lat3 i_rvalid c6", {31'b0, i3_rvalid}, 32'h1);
    chk("lat3 i_rdata c6", i3_rdata, 32'hFFFF_FF7F);
    chk("lat3 d_rvalid c6", {31'b0, d3_rvalid}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
